// File: rtl/zynq_axi_pkg.sv
// zynq_axi_pkg: shared response codes, burst kinds, register indices and FSM states
package zynq_axi_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
  localparam int REG_LED = 0;
  localparam int REG_SCRATCH = 1;
  localparam int REG_ID = 2;
  localparam int REG_CNT = 3;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/zynq_axi_led_slave_bank.sv
// led_reg_bank: 64-bit register storage with byte-strobed write, combinational read, cycle counter and LEDs
module led_reg_bank
  import zynq_axi_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [63:0] BLOCK_ID = 64'h4C45_445F_0001_0000,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic [IW-1:0] ridx,
  output logic [63:0]   rdata,
  output logic [7:0]    leds
);
  logic [63:0] regs [NUM_REGS];
  logic [63:0] cnt;
  // storage updates: ID and counter slots silently drop writes, counter free-runs
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      cnt <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (we && widx != IW'(REG_ID) && widx != IW'(REG_CNT))
        for (int b = 0; b < 8; b++) if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  // read port returns the pre-write value when a write lands in the same cycle
  always_comb rdata = (ridx == IW'(REG_ID)) ? BLOCK_ID : (ridx == IW'(REG_CNT)) ? cnt : regs[ridx];
  assign leds = regs[IW'(REG_LED)][7:0];
endmodule

// File: rtl/zynq_axi_led_slave.sv
// zynq_axi_led_slave: AXI4 slave terminating the PS master with an LED/scratch/ID/counter register bank
module zynq_axi_led_slave
  import zynq_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH = 16,
  parameter int USER_WIDTH = 16,
  parameter int NUM_REGS = 16,
  parameter logic [63:0] BLOCK_ID = 64'h4C45_445F_0001_0000
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [3:0]            s_axi_awcache,
  input  logic                  s_axi_awlock,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic [USER_WIDTH-1:0] s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [3:0]            s_axi_arcache,
  input  logic                  s_axi_arlock,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            leds
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [12:0] LIM = 13'(NUM_REGS * 8);
  function automatic logic [1:0] beat_resp(input logic bad, input logic [12:0] off);
    return bad ? SLVERR : (off >= LIM) ? DECERR : OKAY;
  endfunction
  wstate_t w_state;
  rstate_t r_state;
  logic [ID_WIDTH-1:0] w_id;
  logic [12:0] w_off, r_off, r_sel;
  logic w_fixed, w_bad, r_fixed, r_bad, aw_bad, ar_bad, w_fire, w_last, r_fire, we;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [1:0] w_acc, w_beat, r_resp_n;
  logic [63:0] bank_rdata;
  logic unused;
  assign unused = ^{s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_araddr[ADDR_WIDTH-1:12], s_axi_awcache, s_axi_awlock,
                    s_axi_awprot, s_axi_awqos, s_axi_awuser, s_axi_arcache, s_axi_arlock, s_axi_arprot,
                    s_axi_arqos, s_axi_aruser};
  assign s_axi_awready = (w_state == W_IDLE) && !axi_rst;
  assign s_axi_arready = (r_state == R_IDLE) && !axi_rst;
  // beat classification; a wlast that disagrees with the beat counter forces at least SLVERR
  always_comb begin
    aw_bad = s_axi_awsize != 3'd3 || (s_axi_awburst != FIXED && s_axi_awburst != INCR);
    ar_bad = s_axi_arsize != 3'd3 || (s_axi_arburst != FIXED && s_axi_arburst != INCR);
    w_fire = s_axi_wvalid && s_axi_wready;
    w_last = w_cnt == w_len;
    w_beat = worst_resp(beat_resp(w_bad, w_off), (s_axi_wlast != w_last) ? SLVERR : OKAY);
    we = w_fire && beat_resp(w_bad, w_off) == OKAY;
    r_fire = s_axi_rvalid && s_axi_rready;
    r_sel = (r_state == R_IDLE) ? {1'b0, s_axi_araddr[11:0]} : (r_fixed ? r_off : r_off + 13'd8);
    r_resp_n = beat_resp((r_state == R_IDLE) ? ar_bad : r_bad, r_sel);
  end
  // write FSM: latch AW, count beats, report worst response over the burst
  always_ff @(posedge axi_clk)
    if (axi_rst) begin
      w_state <= W_IDLE;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bid <= '0;
      s_axi_bresp <= OKAY;
      w_id <= '0;
      w_off <= '0;
      w_fixed <= 1'b0;
      w_bad <= 1'b0;
      w_len <= '0;
      w_cnt <= '0;
      w_acc <= OKAY;
    end else
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_state <= W_DATA;
          s_axi_wready <= 1'b1;
          w_id <= s_axi_awid;
          w_off <= {1'b0, s_axi_awaddr[11:0]};
          w_fixed <= s_axi_awburst == FIXED;
          w_bad <= aw_bad;
          w_len <= s_axi_awlen;
          w_cnt <= '0;
          w_acc <= OKAY;
        end
        W_DATA: if (w_fire) begin
          if (w_last) begin
            w_state <= W_RESP;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bid <= w_id;
            s_axi_bresp <= worst_resp(w_acc, w_beat);
          end else begin
            w_acc <= worst_resp(w_acc, w_beat);
            w_cnt <= w_cnt + 8'd1;
            w_off <= w_fixed ? w_off : w_off + 13'd8;
          end
        end
        W_RESP: if (s_axi_bready) begin
          w_state <= W_IDLE;
          s_axi_bvalid <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
  // read FSM: each beat's data is fetched on the cycle that makes it visible, held until accepted
  always_ff @(posedge axi_clk)
    if (axi_rst) begin
      r_state <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= OKAY;
      s_axi_rlast <= 1'b0;
      r_off <= '0;
      r_fixed <= 1'b0;
      r_bad <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
    end else
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          r_state <= R_DATA;
          s_axi_rvalid <= 1'b1;
          s_axi_rid <= s_axi_arid;
          s_axi_rdata <= (r_resp_n == OKAY) ? bank_rdata : 64'd0;
          s_axi_rresp <= r_resp_n;
          s_axi_rlast <= s_axi_arlen == 8'd0;
          r_off <= r_sel;
          r_fixed <= s_axi_arburst == FIXED;
          r_bad <= ar_bad;
          r_len <= s_axi_arlen;
          r_cnt <= '0;
        end
        R_DATA: if (r_fire) begin
          if (s_axi_rlast) begin
            r_state <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast <= 1'b0;
          end else begin
            r_off <= r_sel;
            r_cnt <= r_cnt + 8'd1;
            s_axi_rdata <= (r_resp_n == OKAY) ? bank_rdata : 64'd0;
            s_axi_rresp <= r_resp_n;
            s_axi_rlast <= r_cnt + 8'd1 == r_len;
          end
        end
        default: r_state <= R_IDLE;
      endcase
  led_reg_bank #(.NUM_REGS(NUM_REGS), .BLOCK_ID(BLOCK_ID)) u_bank (
    .clk(axi_clk),
    .rst(axi_rst),
    .we(we),
    .widx(w_off[3 +: IW]),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .ridx(r_sel[3 +: IW]),
    .rdata(bank_rdata),
    .leds(leds)
  );
endmodule

// File: tb/tb_zynq_axi_led_slave.sv
// tb_zynq_axi_led_slave: randomized AXI traffic against a register-map model with a queue scoreboard
module tb_zynq_axi_led_slave;
  localparam int NR = 16;
  localparam logic [63:0] BID = 64'h4C45_445F_0001_0000;
  typedef logic [63:0] dq_t[$];
  typedef struct {logic [63:0] data; logic [1:0] resp; logic last; logic [15:0] id; bit chk; bit cnt;} rexp_t;
  typedef struct {logic [1:0] resp; logic [15:0] id;} bexp_t;
  logic axi_clk = 0, axi_rst = 1;
  logic [15:0] s_axi_awid = 0, s_axi_arid = 0, s_axi_bid, s_axi_rid;
  logic [39:0] s_axi_awaddr = 0, s_axi_araddr = 0;
  logic [7:0] s_axi_awlen = 0, s_axi_arlen = 0, s_axi_wstrb = 0, leds;
  logic [2:0] s_axi_awsize = 3, s_axi_arsize = 3;
  logic [1:0] s_axi_awburst = 1, s_axi_arburst = 1, s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1;
  logic [63:0] s_axi_wdata = 0, s_axi_rdata;
  logic [63:0] mem[NR];
  rexp_t rq[$];
  bexp_t bq[$];
  logic [63:0] cnt_seen[$];
  int total = 0, bad = 0;
  bit sb_off = 0, rmode = 0;
  zynq_axi_led_slave dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(4'd0),
    .s_axi_awlock(1'b0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awuser(16'd0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(4'd0),
    .s_axi_arlock(1'b0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_aruser(16'd0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .leds(leds)
  );
  always #5 axi_clk = ~axi_clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s: got no handshake, want one within the cycle budget", name);
  endtask
  function automatic dq_t rnd_data(input int n);
    dq_t q;
    for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
    return q;
  endfunction
  // backpressure on R and B: always ready, or random when rmode is set
  initial forever begin
    @(posedge axi_clk);
    #1;
    s_axi_rready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    s_axi_bready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // monitor: pops the scoreboard on each accepted B/R beat and checks held outputs under backpressure
  rexp_t re;
  bexp_t be;
  logic p_rv = 0, p_rr = 0, p_bv = 0, p_br = 0;
  logic [63:0] p_rd = 0, p_rc = 0, p_bc = 0;
  always @(negedge axi_clk) begin
    if (sb_off) begin
      p_rv = 0;
      p_bv = 0;
    end else begin
      if (p_rv && !p_rr) begin
        chk("r_hold_data", s_axi_rdata, p_rd);
        chk("r_hold_ctl", 64'({s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid}), p_rc);
      end
      if (p_bv && !p_br) chk("b_hold", 64'({s_axi_bvalid, s_axi_bresp, s_axi_bid}), p_bc);
      if (s_axi_bvalid && s_axi_bready) begin
        if (bq.size() == 0) chk("b_unexpected", 64'(s_axi_bvalid), 64'd0);
        else begin
          be = bq.pop_front();
          chk("bresp", 64'(s_axi_bresp), 64'(be.resp));
          chk("bid", 64'(s_axi_bid), 64'(be.id));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) chk("r_unexpected", 64'(s_axi_rvalid), 64'd0);
        else begin
          re = rq.pop_front();
          chk("rresp", 64'(s_axi_rresp), 64'(re.resp));
          chk("rlast", 64'(s_axi_rlast), 64'(re.last));
          chk("rid", 64'(s_axi_rid), 64'(re.id));
          if (re.chk) chk("rdata", s_axi_rdata, re.data);
          if (re.cnt) cnt_seen.push_back(s_axi_rdata);
        end
      end
      p_rv = s_axi_rvalid;
      p_rr = s_axi_rready;
      p_rd = s_axi_rdata;
      p_rc = 64'({s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid});
      p_bv = s_axi_bvalid;
      p_br = s_axi_bready;
      p_bc = 64'({s_axi_bvalid, s_axi_bresp, s_axi_bid});
    end
  end
  task automatic axi_write(input logic [39:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input dq_t data, input logic [7:0] strb,
                           input int early, input logic [15:0] id);
    bit sl;
    int off0, w;
    sl = (size != 3'd3) || (burst > 2'd1);
    off0 = int'(addr[11:0]);
    w = 0;
    @(posedge axi_clk);
    #1;
    s_axi_awid = id;
    s_axi_awaddr = addr;
    s_axi_awlen = len;
    s_axi_awsize = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1;
    for (int n = 0; ; n++) begin
      @(negedge axi_clk);
      if (s_axi_awready) break;
      if (n == 200) begin tmo("aw"); break; end
    end
    @(posedge axi_clk);
    #1;
    s_axi_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      int off, r;
      off = off0 + (burst == 2'd0 ? 0 : 8 * i);
      s_axi_wdata = data[i];
      s_axi_wstrb = strb;
      s_axi_wlast = (early >= 0) ? (i == early) : (i == int'(len));
      s_axi_wvalid = 1;
      for (int n = 0; ; n++) begin
        @(negedge axi_clk);
        if (i > 0 && n == 0) chk("leds", 64'(leds), 64'(mem[0][7:0]));
        if (s_axi_wready) break;
        if (n == 200) begin tmo("w"); break; end
      end
      r = sl ? 2 : (off >= NR * 8) ? 3 : 0;
      if (s_axi_wlast != (i == int'(len)) && r < 2) r = 2;
      if (r > w) w = r;
      if (!sl && off < NR * 8 && off / 8 != 2 && off / 8 != 3)
        for (int b = 0; b < 8; b++) if (strb[b]) mem[off / 8][b * 8 +: 8] = data[i][b * 8 +: 8];
      @(posedge axi_clk);
      #1;
    end
    s_axi_wvalid = 0;
    s_axi_wlast = 0;
    bq.push_back('{resp: 2'(w), id: id});
    @(negedge axi_clk);
    chk("leds", 64'(leds), 64'(mem[0][7:0]));
  endtask
  task automatic axi_read(input logic [39:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [15:0] id);
    bit sl;
    int off0;
    sl = (size != 3'd3) || (burst > 2'd1);
    off0 = int'(addr[11:0]);
    @(posedge axi_clk);
    #1;
    s_axi_arid = id;
    s_axi_araddr = addr;
    s_axi_arlen = len;
    s_axi_arsize = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1;
    for (int i = 0; i <= int'(len); i++) begin
      int off, r;
      rexp_t e;
      off = off0 + (burst == 2'd0 ? 0 : 8 * i);
      r = sl ? 2 : (off >= NR * 8) ? 3 : 0;
      e.resp = 2'(r);
      e.last = i == int'(len);
      e.id = id;
      e.cnt = r == 0 && off / 8 == 3;
      e.chk = !e.cnt;
      e.data = (r != 0) ? 64'd0 : (off / 8 == 2) ? BID : (off / 8 == 3) ? 64'd0 : mem[off / 8];
      rq.push_back(e);
    end
    for (int n = 0; ; n++) begin
      @(negedge axi_clk);
      if (s_axi_arready) break;
      if (n == 200) begin tmo("ar"); break; end
    end
    @(posedge axi_clk);
    #1;
    s_axi_arvalid = 0;
  endtask
  task automatic drain();
    for (int n = 0; rq.size() != 0 || bq.size() != 0; n++) begin
      @(negedge axi_clk);
      if (n == 400) begin
        tmo("drain");
        rq.delete();
        bq.delete();
        break;
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < NR; i++) mem[i] = 0;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_bvalid", 64'(s_axi_bvalid), 0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 0);
    chk("rst_wready", 64'(s_axi_wready), 0);
    chk("rst_awready", 64'(s_axi_awready), 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_leds", 64'(leds), 0);
    @(posedge axi_clk);
    #1;
    axi_rst = 0;
    @(negedge axi_clk);
    chk("idle_awready", 64'(s_axi_awready), 1);
    chk("idle_arready", 64'(s_axi_arready), 1);
    axi_write(40'h0, 0, 3, 1, '{64'hA5}, 8'hFF, -1, 16'h11);
    axi_read(40'h0, 0, 3, 1, 16'h12);
    drain();
    rmode = 1;
    axi_write(40'h20, 3, 3, 1, rnd_data(4), 8'hFF, -1, 16'h21);
    axi_read(40'h20, 3, 3, 1, 16'h22);
    drain();
    rmode = 0;
    axi_write(40'h10, 0, 3, 1, '{64'hFFFF_FFFF_FFFF_FFFF}, 8'hFF, -1, 16'h31);
    axi_read(40'h10, 0, 3, 1, 16'h32);
    drain();
    cnt_seen.delete();
    axi_read(40'h18, 0, 3, 1, 16'h33);
    drain();
    repeat (10) @(posedge axi_clk);
    axi_read(40'h18, 0, 3, 1, 16'h34);
    drain();
    if (cnt_seen.size() == 2) chk("cnt_diff_ge_10", 64'(cnt_seen[1] - cnt_seen[0] >= 10), 1);
    else chk("cnt_reads", 64'(cnt_seen.size()), 2);
    axi_read(40'h80, 0, 3, 1, 16'h41);
    axi_read(40'h78, 1, 3, 1, 16'h42);
    axi_write(40'h78, 1, 3, 1, rnd_data(2), 8'h0F, -1, 16'h43);
    drain();
    axi_write(40'h8, 1, 3, 2, rnd_data(2), 8'hFF, -1, 16'h51);
    axi_read(40'h8, 0, 3, 1, 16'h52);
    axi_read(40'h8, 0, 2, 1, 16'h53);
    axi_write(40'h20, 3, 3, 1, rnd_data(4), 8'h3C, 1, 16'h54);
    axi_read(40'h20, 3, 3, 0, 16'h55);
    axi_read(40'h20, 3, 3, 1, 16'h56);
    drain();
    fork
      axi_write(40'h8, 0, 3, 1, rnd_data(1), 8'hFF, -1, 16'h61);
      begin
        @(posedge axi_clk);
        axi_read(40'h8, 0, 3, 1, 16'h62);
      end
    join
    drain();
    axi_read(40'h8, 0, 3, 1, 16'h63);
    drain();
    rmode = 1;
    for (int k = 0; k < 60; k++) begin
      logic [39:0] a;
      logic [7:0] l;
      logic [2:0] s;
      logic [1:0] b;
      a = {28'($urandom), 12'($urandom_range(0, NR + 1) * 8)};
      l = 8'($urandom_range(0, 3));
      b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, l, s, b, rnd_data(int'(l) + 1), 8'($urandom),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(l))) : -1, 16'($urandom));
      else axi_read(a, l, s, b, 16'($urandom));
      drain();
    end
    rmode = 0;
    repeat (2) @(posedge axi_clk);
    sb_off = 1;
    #1;
    s_axi_araddr = 40'h20;
    s_axi_arlen = 7;
    s_axi_arsize = 3;
    s_axi_arburst = 1;
    s_axi_arvalid = 1;
    for (int n = 0; ; n++) begin
      @(negedge axi_clk);
      if (s_axi_arready) break;
      if (n == 200) begin tmo("ar_rst"); break; end
    end
    @(posedge axi_clk);
    #1;
    s_axi_arvalid = 0;
    @(posedge axi_clk);
    #1;
    axi_rst = 1;
    @(negedge axi_clk);
    chk("beat2_rvalid", 64'(s_axi_rvalid), 1);
    @(negedge axi_clk);
    chk("rst_mid_rvalid", 64'(s_axi_rvalid), 0);
    chk("rst_mid_rlast", 64'(s_axi_rlast), 0);
    chk("rst_mid_leds", 64'(leds), 0);
    @(posedge axi_clk);
    #1;
    axi_rst = 0;
    for (int i = 0; i < NR; i++) mem[i] = 0;
    @(negedge axi_clk);
    chk("post_rst_awready", 64'(s_axi_awready), 1);
    chk("post_rst_arready", 64'(s_axi_arready), 1);
    rq.delete();
    bq.delete();
    sb_off = 0;
    axi_read(40'h20, 1, 3, 1, 16'h71);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
